// File: rtl/gray_pkg.sv
// Shared width default and binary/Gray conversion helpers for the Gray counter.
package gray_pkg;

    localparam int unsigned GRAY_WIDTH     = 4;
    localparam int unsigned GRAY_MAX_WIDTH = 16;

    function automatic logic [GRAY_MAX_WIDTH-1:0] bin2gray(input logic [GRAY_MAX_WIDTH-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    // Zero-extended codes stay valid: the top bit of the Gray code equals the top binary bit.
    function automatic logic [GRAY_MAX_WIDTH-1:0] gray2bin(input logic [GRAY_MAX_WIDTH-1:0] gray);
        logic [GRAY_MAX_WIDTH-1:0] bin;
        bin[GRAY_MAX_WIDTH-1] = gray[GRAY_MAX_WIDTH-1];
        for (int i = GRAY_MAX_WIDTH - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/bin2gray_enc.sv
// Combinational binary-to-Gray encoder.
module bin2gray_enc
    import gray_pkg::*;
#(
    parameter int unsigned WIDTH = GRAY_WIDTH
) (
    input  logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray_c
);

    localparam int unsigned MW = GRAY_MAX_WIDTH;

    always_comb begin
        gray_c = WIDTH'(bin2gray(MW'(bin)));
    end

endmodule

// File: rtl/gray_counter.sv
// Up/down Gray counter with load, valid/ready output handshake and wrap indicator.
module gray_counter
    import gray_pkg::*;
#(
    parameter int unsigned WIDTH = GRAY_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             out_ready,
    output logic [WIDTH-1:0] bin_q,
    output logic [WIDTH-1:0] gray_q,
    output logic             out_valid,
    output logic             tc
);

    localparam logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}};

    logic             advance_c;
    logic             wrap_c;
    logic             valid_next_c;
    logic             tc_next_c;
    logic [WIDTH-1:0] bin_next_c;
    logic [WIDTH-1:0] gray_next_c;

    // out_ready only matters while a code is waiting to be accepted.
    always_comb begin
        advance_c    = en & ~load & (~out_valid | out_ready);
        wrap_c       = 1'b0;
        bin_next_c   = bin_q;
        valid_next_c = out_valid;
        tc_next_c    = tc;

        if (load) begin
            bin_next_c   = load_val;
            valid_next_c = 1'b1;
            tc_next_c    = 1'b0;
        end else if (advance_c) begin
            if (up_dn) begin
                bin_next_c = bin_q + WIDTH'(1);
                wrap_c     = (bin_q == MAX_VAL);
            end else begin
                bin_next_c = bin_q - WIDTH'(1);
                wrap_c     = (bin_q == '0);
            end
            valid_next_c = 1'b1;
            tc_next_c    = wrap_c;
        end else if (out_valid && out_ready) begin
            valid_next_c = 1'b0;
        end
    end

    bin2gray_enc #(
        .WIDTH (WIDTH)
    ) u_enc (
        .bin    (bin_next_c),
        .gray_c (gray_next_c)
    );

    // Binary and Gray copies update on the same edge so they never disagree.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_q     <= '0;
            gray_q    <= '0;
            out_valid <= 1'b0;
            tc        <= 1'b0;
        end else begin
            bin_q     <= bin_next_c;
            gray_q    <= gray_next_c;
            out_valid <= valid_next_c;
            tc        <= tc_next_c;
        end
    end

endmodule

// File: doc/gray_counter.md
GRAY_COUNTER -- requirements
Module: gray_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 4: counter width in bits, legal range 2..16.
REQ-002 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous reset, active-low.
REQ-004 SHALL have port en, input, 1 bit: count enable.
REQ-005 SHALL have port up_dn, input, 1 bit: count direction, 1 = up, 0 = down.
REQ-006 SHALL have port load, input, 1 bit: synchronous load strobe.
REQ-007 SHALL have port load_val, input, WIDTH bits: binary value to load.
REQ-008 SHALL have port out_ready, input, 1 bit: downstream accepts the current code.
REQ-009 SHALL have port bin_q, output, WIDTH bits: registered binary count.
REQ-010 SHALL have port gray_q, output, WIDTH bits: registered Gray code of bin_q.
REQ-011 SHALL have port out_valid, output, 1 bit: gray_q holds a new code not yet accepted.
REQ-012 SHALL have port tc, output, 1 bit: wrap indicator, asserted with the code produced by a wrap.

Function
REQ-013 SHALL keep gray_q equal to bin_q ^ (bin_q >> 1) in every cycle, with both registered on the same edge.
REQ-014 SHALL define advance = en & ~load & (~out_valid | out_ready).
REQ-015 On advance, SHALL set bin_q to bin_q+1 when up_dn=1, or bin_q-1 when up_dn=0, modulo 2^WIDTH, with 1-cycle latency.
REQ-016 SHALL give load priority over en and over any stall: bin_q <= load_val on the next edge, regardless of out_ready.
REQ-017 SHALL set out_valid=1 on the edge after any load or advance.
REQ-018 SHALL clear out_valid on the edge where out_valid=1, out_ready=1, and neither load nor advance occurs.
REQ-019 SHALL hold bin_q, gray_q and out_valid stable while out_valid=1 and out_ready=0, unless load=1 (stall).
REQ-020 SHALL assert tc for exactly the cycle(s) in which gray_q holds a code produced by a wrap: up from 2^WIDTH-1 to 0, or down from 0 to 2^WIDTH-1.
REQ-021 SHALL hold tc while that wrapped code is stalled, and SHALL clear tc on the next load or non-wrapping advance.
REQ-022 SHALL never assert tc because of a load, even when load_val equals 0 or 2^WIDTH-1.
REQ-023 SHALL change exactly one bit of gray_q on every advance, including wrap and direction reversal.
REQ-024 SHALL take the new direction on the next advance when up_dn changes, with no idle cycle.
REQ-025 SHALL treat en=1 with out_ready=X while out_valid=0 as a legal advance (out_ready is ignored when out_valid=0).

Reset
REQ-026 SHALL drive bin_q=0, gray_q=0, out_valid=0 and tc=0 immediately on rst_n=0, independent of clk.
REQ-027 SHALL hold all outputs at their reset values while rst_n=0, ignoring load and en.
REQ-028 SHALL allow the first load or advance on the first rising clk edge after rst_n deasserts.
REQ-029 SHALL drop any in-flight unaccepted code when reset is asserted mid-operation; no recovery state is kept.

Structure
REQ-030 SHALL place the default WIDTH constant in a shared package gray_pkg, together with the binary-to-Gray and Gray-to-binary conversion functions.
REQ-031 SHALL instantiate one combinational sub-module, bin2gray_enc (parameterized WIDTH), on the next-state binary value to produce the next gray_q.
REQ-032 SHALL keep all state in a single always block sensitive to posedge clk and negedge rst_n.

Verification
REQ-033 Reset check: rst_n=0 mid-count at bin_q=4'd9 -> bin_q=0, gray_q=0, out_valid=0, tc=0 without waiting for a clk edge.
REQ-034 Up count and wrap: WIDTH=4, up_dn=1, en=1, out_ready=1, start at 0 -> gray_q sequence 0000,0001,0011,0010,...,1000 then 0000 with tc=1 for one cycle; a model check confirms exactly one bit toggles per step.
REQ-035 Down count and wrap: load_val=4'd1, then up_dn=0, en=1 -> bin_q 1,0,15; gray_q=1000 at 15 with tc=1.
REQ-036 Stall: out_ready=0 for 3 cycles at bin_q=5 (gray_q=0111) -> bin_q, gray_q and out_valid held; with out_ready=1 the next edge gives bin_q=6, gray_q=0101.
REQ-037 Load priority: load=1, load_val=4'd15, en=1, out_valid=1, out_ready=0 -> bin_q=15, gray_q=1000, out_valid=1, tc=0.
REQ-038 Direction reversal: at bin_q=7, up_dn toggles 1->0 with en=1 -> bin_q 8 then 7, gray_q 1100 then 0100, no idle cycle.
